// File: rtl/reg_bank_arbiter.sv
// Register bank shared between an SPI write port and a core request port.
// One access per two cycles; SPI writes are buffered one deep, contention alternates.
module reg_bank_arbiter #(
    parameter int ADDR_W = 3,
    parameter int REG_W  = 8
) (
    input  logic                          clk,
    input  logic                          rstb,
    input  logic                          ena,
    input  logic [ADDR_W-1:0]             spi_addr,
    input  logic [REG_W-1:0]              spi_wdata,
    input  logic                          spi_wdv,
    output logic [REG_W-1:0]              spi_rdata,
    input  logic                          core_req,
    input  logic                          core_we,
    input  logic [ADDR_W-1:0]             core_addr,
    input  logic [REG_W-1:0]              core_wdata,
    output logic                          core_gnt,
    output logic [REG_W-1:0]              core_rdata,
    output logic                          core_rvalid,
    output logic [(2**ADDR_W)*REG_W-1:0]  regs_flat,
    output logic [7:0]                    status
);

    localparam int NREG = 2**ADDR_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SPI_WR   = 2'd1,
        CORE_ACC = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [REG_W-1:0]   regs_q [NREG];
    logic [ADDR_W-1:0]  pend_addr_q;
    logic [REG_W-1:0]   pend_data_q;
    logic               pend_valid_q;
    logic               ovf_q;
    logic [4:0]         cnt_q;
    logic               last_spi_q;
    logic [REG_W-1:0]   spi_rdata_q;
    logic [REG_W-1:0]   core_rdata_q;
    logic               core_rvalid_q;

    logic               lock;
    logic               spi_served;
    logic               core_wr_en;
    logic               core_rd_en;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [REG_W-1:0]   wr_data;
    logic [REG_W-1:0]   wr_word;
    logic               clr_status;
    logic               contention;

    // Core handshake: core_req/we/addr/wdata are held stable until the cycle
    // core_gnt is high; the access completes at the end of that cycle.
    always_comb begin
        lock       = regs_q[0][7];
        spi_served = (state_q == SPI_WR);
        core_wr_en = (state_q == CORE_ACC) && core_we && !lock;
        core_rd_en = (state_q == CORE_ACC) && !core_we;
        wr_en      = spi_served || core_wr_en;
        wr_addr    = spi_served ? pend_addr_q : core_addr;
        wr_data    = spi_served ? pend_data_q : core_wdata;
        wr_word    = wr_data;
        // Clear-status bit is a strobe; it is never stored.
        if (wr_addr == '0) wr_word = {wr_data[REG_W-1:7], 1'b0, wr_data[5:0]};
        clr_status = wr_en && (wr_addr == '0) && wr_data[6];
        contention = (state_q == IDLE) && pend_valid_q && core_req;
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE: begin
                if (pend_valid_q && core_req) state_d = last_spi_q ? CORE_ACC : SPI_WR;
                else if (pend_valid_q)        state_d = SPI_WR;
                else if (core_req)            state_d = CORE_ACC;
            end
            SPI_WR:   state_d = IDLE;
            CORE_ACC: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q       <= IDLE;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            pend_addr_q   <= '0;
            pend_data_q   <= '0;
            pend_valid_q  <= 1'b0;
            ovf_q         <= 1'b0;
            cnt_q         <= '0;
            last_spi_q    <= 1'b0;
            spi_rdata_q   <= '0;
            core_rdata_q  <= '0;
            core_rvalid_q <= 1'b0;
        end else if (ena) begin
            state_q       <= state_d;
            spi_rdata_q   <= regs_q[spi_addr];
            if (wr_en) regs_q[wr_addr] <= wr_word;
            core_rvalid_q <= core_rd_en;
            if (core_rd_en) core_rdata_q <= regs_q[core_addr];

            // A strobe in the serve cycle refills the buffer without overflow.
            if (spi_wdv) begin
                pend_addr_q  <= spi_addr;
                pend_data_q  <= spi_wdata;
                pend_valid_q <= 1'b1;
            end else if (spi_served) begin
                pend_valid_q <= 1'b0;
            end

            if (clr_status) ovf_q <= 1'b0;
            if (spi_wdv && pend_valid_q && !spi_served) ovf_q <= 1'b1;

            if (clr_status)                         cnt_q <= '0;
            else if (contention && cnt_q != 5'd31)  cnt_q <= cnt_q + 5'd1;

            if (spi_served)                 last_spi_q <= 1'b1;
            else if (state_q == CORE_ACC)   last_spi_q <= 1'b0;
        end
    end

    generate
        for (genvar g = 0; g < NREG; g++) begin : g_flat
            assign regs_flat[g*REG_W +: REG_W] = regs_q[g];
        end
    endgenerate

    assign status      = {ovf_q, pend_valid_q, lock, cnt_q};
    assign spi_rdata   = spi_rdata_q;
    assign core_rdata  = core_rdata_q;
    assign core_gnt    = (state_q == CORE_ACC) && ena;
    assign core_rvalid = core_rvalid_q && ena;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Bench for reg_bank_arbiter: directed scenarios then randomized traffic,
// every cycle compared against a transaction-level model of the register bank.
module tb_reg_bank_arbiter;

    localparam int ACC_NONE = 0;
    localparam int ACC_SPI  = 1;
    localparam int ACC_CORE = 2;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        ena = 1'b1;
    logic [2:0]  spi_addr = '0;
    logic [7:0]  spi_wdata = '0;
    logic        spi_wdv = 1'b0;
    logic [7:0]  spi_rdata;
    logic        core_req = 1'b0;
    logic        core_we = 1'b0;
    logic [2:0]  core_addr = '0;
    logic [7:0]  core_wdata = '0;
    logic        core_gnt;
    logic [7:0]  core_rdata;
    logic        core_rvalid;
    logic [63:0] regs_flat;
    logic [7:0]  status;

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;
    int gnt_seen = 0;

    reg_bank_arbiter #(.ADDR_W(3), .REG_W(8)) dut (
        .clk(clk), .rstb(rstb), .ena(ena),
        .spi_addr(spi_addr), .spi_wdata(spi_wdata), .spi_wdv(spi_wdv), .spi_rdata(spi_rdata),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rdata(core_rdata), .core_rvalid(core_rvalid),
        .regs_flat(regs_flat), .status(status)
    );

    always #5 clk = ~clk;

    // Reference model: the bank, a one-deep SPI mailbox, and the access
    // currently owning the bank (granted at one edge, completed at the next).
    logic [7:0] mregs [8];
    bit         m_pv = 0;
    logic [2:0] m_pa = '0;
    logic [7:0] m_pd = '0;
    bit         m_ovf = 0;
    int         m_cnt = 0;
    int         m_acc = ACC_NONE;
    bit         m_last_spi = 0;
    bit         m_rvalid = 0;
    logic [7:0] m_rdata = '0;
    logic [7:0] m_spi_rdata = '0;
    bit         m_core_done = 0;

    task automatic model_write(input logic [2:0] a, input logic [7:0] d);
        if (a == 3'd0) begin
            if (d[6]) begin
                m_ovf = 0;
                m_cnt = 0;
            end
            mregs[0] = d & 8'hBF;
        end else begin
            mregs[a] = d;
        end
    endtask

    always @(posedge clk) begin
        bit old_pv, served, lk;
        m_core_done = 0;
        if (!rstb) begin
            for (int i = 0; i < 8; i++) mregs[i] = '0;
            m_pv = 0; m_pa = '0; m_pd = '0; m_ovf = 0; m_cnt = 0;
            m_acc = ACC_NONE; m_last_spi = 0; m_rvalid = 0;
            m_rdata = '0; m_spi_rdata = '0;
        end else if (ena) begin
            old_pv = m_pv;
            served = (m_acc == ACC_SPI);
            lk = mregs[0][7];
            m_spi_rdata = mregs[spi_addr];
            m_rvalid = 0;
            if (m_acc == ACC_SPI) begin
                model_write(m_pa, m_pd);
                m_pv = 0;
                m_last_spi = 1;
                m_acc = ACC_NONE;
            end else if (m_acc == ACC_CORE) begin
                if (core_we) begin
                    if (!lk) model_write(core_addr, core_wdata);
                end else begin
                    m_rdata = mregs[core_addr];
                    m_rvalid = 1;
                end
                m_last_spi = 0;
                m_acc = ACC_NONE;
                m_core_done = 1;
            end else if (old_pv && core_req) begin
                if (m_cnt < 31) m_cnt++;
                m_acc = m_last_spi ? ACC_CORE : ACC_SPI;
            end else if (old_pv) begin
                m_acc = ACC_SPI;
            end else if (core_req) begin
                m_acc = ACC_CORE;
            end
            if (spi_wdv) begin
                if (old_pv && !served) m_ovf = 1;
                m_pa = spi_addr;
                m_pd = spi_wdata;
                m_pv = 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: compare at the falling edge, then update the drivers.
    task automatic cyc();
        logic [63:0] exp_flat;
        @(negedge clk);
        if (checking) begin
            for (int i = 0; i < 8; i++) exp_flat[i*8 +: 8] = mregs[i];
            check("regs_flat", regs_flat, exp_flat);
            check("status", {56'd0, status}, {56'd0, m_ovf, m_pv, mregs[0][7], 5'(m_cnt)});
            check("spi_rdata", {56'd0, spi_rdata}, {56'd0, m_spi_rdata});
            check("core_gnt", {63'd0, core_gnt}, {63'd0, (m_acc == ACC_CORE) && ena});
            check("core_rvalid", {63'd0, core_rvalid}, {63'd0, m_rvalid && ena});
            check("core_rdata", {56'd0, core_rdata}, {56'd0, m_rdata});
        end
        if (core_gnt === 1'b1) gnt_seen++;
        spi_wdv = 1'b0;
        if (m_core_done) core_req = 1'b0;
    endtask

    task automatic spi_write(input logic [2:0] a, input logic [7:0] d);
        spi_addr = a;
        spi_wdata = d;
        spi_wdv = 1'b1;
        cyc();
    endtask

    task automatic core_issue(input logic we, input logic [2:0] a, input logic [7:0] d);
        core_req = 1'b1;
        core_we = we;
        core_addr = a;
        core_wdata = d;
    endtask

    task automatic wait_quiet(input string tag);
        bit quiet;
        quiet = 0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (!m_pv && !core_req && m_acc == ACC_NONE) begin
                quiet = 1;
                break;
            end
        end
        check(tag, {63'd0, quiet}, 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstb = 1'b0;
        repeat (2) @(negedge clk);
        checking = 1'b1;
        cyc();
        check("reset_regs", regs_flat, 64'd0);
        check("reset_status", {56'd0, status}, 64'd0);
        check("reset_gnt", {63'd0, core_gnt}, 64'd0);
        rstb = 1'b1;

        // SPI write lands in the bank; readback has one cycle of latency.
        spi_write(3'd3, 8'hA5);
        spi_addr = 3'd3;
        wait_quiet("r020_quiet");
        cyc();
        check("r020_reg3", {56'd0, regs_flat[31:24]}, 64'hA5);
        check("r020_spi_rdata", {56'd0, spi_rdata}, 64'hA5);

        // A core read first so the SPI side wins the upcoming tie.
        core_issue(1'b0, 3'd2, 8'h00);
        wait_quiet("r021_pre");
        spi_write(3'd5, 8'h3C);
        core_issue(1'b0, 3'd3, 8'h00);
        wait_quiet("r021_quiet");
        check("r021_core_rdata", {56'd0, core_rdata}, 64'hA5);
        check("r021_count", {59'd0, status[4:0]}, 64'd1);
        check("r021_reg5", {56'd0, regs_flat[47:40]}, 64'h3C);

        // Back-to-back SPI strobes while the core owns the bank.
        core_issue(1'b1, 3'd6, 8'h66);
        spi_write(3'd4, 8'h11);
        spi_write(3'd4, 8'h22);
        wait_quiet("r022_quiet");
        check("r022_reg4", {56'd0, regs_flat[39:32]}, 64'h22);
        check("r022_ovf", {63'd0, status[7]}, 64'd1);
        check("r022_reg6", {56'd0, regs_flat[55:48]}, 64'h66);

        // Lock blocks core writes but still grants; clear-status wipes ovf/count.
        spi_write(3'd0, 8'h80);
        wait_quiet("r023_lock_quiet");
        check("r023_lock", {63'd0, status[5]}, 64'd1);
        gnt_seen = 0;
        core_issue(1'b1, 3'd1, 8'h55);
        wait_quiet("r023_core_quiet");
        check("r023_gnt_count", 64'(gnt_seen), 64'd1);
        check("r023_reg1", {56'd0, regs_flat[15:8]}, 64'h00);
        spi_write(3'd0, 8'h40);
        wait_quiet("r023_clr_quiet");
        check("r023_status", {56'd0, status}, 64'h00);
        check("r023_reg0", {56'd0, regs_flat[7:0]}, 64'h00);

        // Enable low freezes everything, including pending requests.
        spi_write(3'd2, 8'h77);
        ena = 1'b0;
        core_issue(1'b0, 3'd2, 8'h00);
        gnt_seen = 0;
        repeat (5) cyc();
        check("r024_no_gnt", 64'(gnt_seen), 64'd0);
        check("r024_pending", {63'd0, status[6]}, 64'd1);
        ena = 1'b1;
        wait_quiet("r024_quiet");
        check("r024_reg2", {56'd0, regs_flat[23:16]}, 64'h77);

        // Reset while the core write is being granted aborts it.
        core_issue(1'b1, 3'd7, 8'h99);
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (m_acc == ACC_CORE) break;
        end
        check("r025_in_access", {63'd0, core_gnt}, 64'd1);
        rstb = 1'b0;
        cyc();
        check("r025_regs", regs_flat, 64'd0);
        check("r025_status", {56'd0, status}, 64'd0);
        check("r025_outs", {46'd0, core_gnt, core_rvalid, spi_rdata, core_rdata}, 64'd0);
        rstb = 1'b1;
        wait_quiet("r025_quiet");
        check("r025_reg7", {56'd0, regs_flat[63:56]}, 64'h99);

        // Randomized traffic.
        for (int n = 0; n < 800; n++) begin
            ena = ($urandom_range(0, 9) != 0);
            rstb = ($urandom_range(0, 99) != 0);
            spi_addr = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) begin
                spi_wdata = 8'($urandom_range(0, 255));
                spi_wdv = 1'b1;
            end
            if (!core_req && $urandom_range(0, 2) == 0)
                core_issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                           8'($urandom_range(0, 255)));
            cyc();
        end
        rstb = 1'b1;
        ena = 1'b1;
        wait_quiet("rand_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
